// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end for the five-stage DLX pipeline. Issues
// sequential word fetches to a variable-latency instruction memory and
// buffers the returned words, tagged with their PC+4, in a small FIFO.
// Decode sees the FIFO head. A branch/jump redirect from ID flushes the
// queue and restarts fetch at the target.
//
// Ports
//   clk              pipeline clock, all state changes on the rising edge
//   reset            synchronous, active-high reset
//   imem_req         fetch request, held until imem_ack
//   imem_addr        word-aligned fetch address, stable while waiting
//   imem_ack         request complete, imem_rdata valid this cycle
//   imem_rdata       fetched instruction word (bit 0 = MSB)
//   redirect         taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc      redirect target
//   stall            ID cannot accept an instruction this cycle
//   inst_id          head instruction (zero when valid_id = 0)
//   pc_plus_four_id  PC+4 of the head instruction (zero when valid_id = 0)
//   valid_id         head entry valid
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [0:31] inst_id,
    output logic [31:0] pc_plus_four_id,
    output logic        valid_id
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

    // Fetch state
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   req_addr_reg;      // address of the request currently held on the bus
    logic          outstanding_reg;   // a request was issued and has not been acked yet
    logic          drop_reg;          // the in-flight response belongs to a flushed stream
    logic          started_reg;       // holds off fetching for one cycle after reset

    // Queue state
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic [0:31]   inst_mem [DEPTH];
    logic [31:0]   pc4_mem  [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [DEPTH-1:0] wen;

    // A request that is already on the bus stays up until acked; a new one is
    // only started when the queue has room for its response. The queue never
    // holds more than DEPTH entries because at most one request is in flight.
    assign imem_req  = !reset && started_reg && (outstanding_reg || (count_reg < DEPTH_C));

    // The held address is latched so a redirect that rewrites fetch_pc cannot
    // disturb a request still waiting for its ack.
    assign imem_addr = outstanding_reg ? req_addr_reg : fetch_pc_reg;

    assign accept = imem_req && imem_ack;
    assign push   = accept && !drop_reg && !redirect;
    assign valid_id = (count_reg != '0);
    assign pop    = valid_id && !stall && !redirect;

    assign inst_id         = valid_id ? inst_mem[rd_ptr_reg] : '0;
    assign pc_plus_four_id = valid_id ? pc4_mem[rd_ptr_reg]  : '0;

    // One-hot write enable per queue slot
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign wen[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage: no reset needed, the outputs are gated by valid_id
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) begin
                inst_mem[i] <= imem_rdata;
                pc4_mem[i]  <= imem_addr + 32'd4;
            end
        end
    end

    // Fetch control
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            req_addr_reg    <= RESET_PC;
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
            started_reg     <= 1'b0;
        end else begin
            started_reg <= 1'b1;

            if (imem_req) begin
                req_addr_reg <= imem_addr;
            end
            outstanding_reg <= imem_req && !imem_ack;

            // A redirect while a request is still waiting marks its response as
            // stale. A second redirect keeps the mark because the same request
            // is still waiting; an ack in the redirect cycle is simply ignored.
            if (redirect) begin
                drop_reg <= imem_req && !imem_ack;
            end else if (accept) begin
                drop_reg <= 1'b0;
            end

            if (redirect) begin
                fetch_pc_reg <= redirect_pc;
            end else if (push) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [0:31] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [0:31] inst_id;
    logic [31:0] pc_plus_four_id;
    logic        valid_id;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .inst_id         (inst_id),
        .pc_plus_four_id (pc_plus_four_id),
        .valid_id        (valid_id)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory responder settings
    int mem_wait = 0;   // cycles the request waits before the ack cycle
    int wait_cnt = 0;

    // Reference model: architectural state kept as plain values and a queue
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    ent_t        m_q[$];
    logic        m_started;
    logic [31:0] m_fetch_pc;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_drop;

    function automatic logic [31:0] word_at(logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: entered at posedge+1 with stall/redirect already driven.
    task automatic step();
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        ent_t        head;

        #1;
        if (imem_req && wait_cnt >= mem_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = word_at(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = '0;
        end
        #1;

        exp_req   = !reset && m_started && (m_pend || (m_q.size() < DEPTH));
        exp_addr  = m_pend ? m_pend_addr : m_fetch_pc;
        exp_valid = (m_q.size() != 0);
        head      = exp_valid ? m_q[0] : '0;

        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        chk("valid_id", 32'(valid_id), 32'(exp_valid));
        chk("inst_id", inst_id, head.inst);
        chk("pc_plus_four_id", pc_plus_four_id, head.pc4);

        if (reset) begin
            m_q.delete();
            m_started  = 1'b0;
            m_fetch_pc = RESET_PC;
            m_pend     = 1'b0;
            m_drop     = 1'b0;
        end else begin
            m_started = 1'b1;
            if (redirect) begin
                m_q.delete();
                m_drop     = exp_req && !imem_ack;
                m_fetch_pc = redirect_pc;
            end else begin
                if (exp_valid && !stall) begin
                    $display("issue pc4=%h inst=%h", head.pc4, head.inst);
                    void'(m_q.pop_front());
                end
                if (exp_req && imem_ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        chk("push_into_full", 32'(m_q.size() < DEPTH), 32'd1);
                        m_q.push_back('{inst: word_at(exp_addr), pc4: exp_addr + 32'd4});
                        m_fetch_pc = m_fetch_pc + 32'd4;
                    end
                end
            end
            m_pend      = exp_req && !imem_ack;
            m_pend_addr = exp_addr;
        end

        if (imem_req && !imem_ack) wait_cnt++;
        else wait_cnt = 0;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int wait_cycles);
        mem_wait = wait_cycles;
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  last_v;
        int  k;
        int  bad;
        bit  found;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(posedge clk);
        #1;

        // 1: reset state and zero-wait streaming
        do_reset(0);
        chk("t1_req_after_reset", 32'(imem_req), 32'd0);
        chk("t1_valid_after_reset", 32'(valid_id), 32'd0);
        step();
        chk("t1_first_req", 32'(imem_req), 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0000_0100);
        step();
        chk("t1_c2_valid", 32'(valid_id), 32'd1);
        chk("t1_c2_pc4", pc_plus_four_id, 32'h0000_0104);
        chk("t1_c2_inst", inst_id, 32'hDEAD_0100);
        chk("t1_c2_addr", imem_addr, 32'h0000_0104);
        step();
        chk("t1_c3_pc4", pc_plus_four_id, 32'h0000_0108);
        chk("t1_c3_addr", imem_addr, 32'h0000_0108);
        for (int i = 0; i < 4; i++) step();

        // 2: stall fills exactly DEPTH entries, then drains in order
        do_reset(0);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_head_inst", inst_id, 32'hDEAD_0100);
        chk("t2_head_pc4", pc_plus_four_id, 32'h0000_0104);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_valid", 32'(valid_id), 32'd1);
            chk("t2_drain_pc4", pc_plus_four_id, 32'h0000_0104 + 32'(4 * i));
            step();
        end

        // 3: three-cycle memory
        do_reset(2);
        last_v = -10;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            if (valid_id) begin
                chk("t3_spacing_ok", 32'((c - last_v) >= 3), 32'd1);
                chk("t3_pc4", pc_plus_four_id, 32'h0000_0104 + 32'(4 * k));
                last_v = c;
                k++;
            end
            step();
        end

        // 4: redirect while the 0x10C request is pending
        do_reset(2);
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (imem_req && imem_addr == 32'h0000_010C) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t4_found_10c", 32'(found), 32'd1);
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        step();
        redirect = 1'b0;
        chk("t4_flushed", 32'(valid_id), 32'd0);
        chk("t4_old_addr_held", imem_addr, 32'h0000_010C);
        step();
        chk("t4_new_req", 32'(imem_req), 32'd1);
        chk("t4_new_addr", imem_addr, 32'h0000_2000);
        chk("t4_still_empty", 32'(valid_id), 32'd0);
        found = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid_id) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t4_target_seen", 32'(found), 32'd1);
        chk("t4_target_pc4", pc_plus_four_id, 32'h0000_2004);
        chk("t4_target_inst", inst_id, 32'hDEAD_2000);
        if (pc_plus_four_id == 32'h0000_0110) bad++;
        chk("t4_no_stale", 32'(bad), 32'd0);
        step();

        // 5: redirect coinciding with an ack and a pop
        do_reset(0);
        for (int i = 0; i < 4; i++) step();
        chk("t5_pre_req", 32'(imem_req), 32'd1);
        chk("t5_pre_valid", 32'(valid_id), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        step();
        redirect = 1'b0;
        chk("t5_empty", 32'(valid_id), 32'd0);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h0000_3000);
        step();
        chk("t5_first_valid", 32'(valid_id), 32'd1);
        chk("t5_first_pc4", pc_plus_four_id, 32'h0000_3004);
        chk("t5_first_inst", inst_id, 32'hDEAD_3000);

        // 6: address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        chk("t6_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("t6_pc4_0", pc_plus_four_id, 32'hFFFF_FFFC);
        chk("t6_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_pc4_1", pc_plus_four_id, 32'h0000_0000);
        chk("t6_addr2", imem_addr, 32'h0000_0000);
        step();
        chk("t6_pc4_2", pc_plus_four_id, 32'h0000_0004);
        chk("t6_inst_2", inst_id, 32'hDEAD_0000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction-fetch front end for the five-stage DLX pipeline. It sits between a variable-latency instruction memory port and the ID stage. It generates sequential fetch addresses and buffers fetched instructions with their PC+4 in a small FIFO. It presents one instruction per cycle to decode, honouring the decode stall and the branch/jump redirect.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, level-held until acknowledged.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  request complete; imem_rdata valid this cycle. May assert in the same cycle as imem_req.
- imem_rdata  in  [0:31]  instruction word, bit 0 = MSB.
- redirect  in  1  taken branch/jump from ID; flush and refetch.
- redirect_pc  in  32  target address, sampled when redirect=1.
- stall  in  1  ID cannot accept an instruction this cycle.
- inst_id  out  [0:31]  head instruction; 32'h0 when valid_id=0.
- pc_plus_four_id  out  32  PC+4 of the head instruction; 32'h0 when valid_id=0.
- valid_id  out  1  head entry valid.

## Operation
- State:
  - fetch_pc (32b)
  - outstanding flag: at most one request in flight
  - drop flag: discard the in-flight response
  - FIFO of DEPTH entries {inst, pc+4}, with rd_ptr, wr_ptr and count (log2(DEPTH)+1 bits)
- Request issue:
  - imem_req=1 when !reset and (count + outstanding) < DEPTH, or when an already-issued request is not yet acked.
  - Once raised, imem_req stays high with a fixed imem_addr until imem_ack, regardless of later count changes.
- On imem_ack with drop=0:
  - Push {imem_rdata, imem_addr+4}.
  - fetch_pc <= fetch_pc + 4, with 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
- On imem_ack with drop=1:
  - Discard the data.
  - Clear drop.
  - fetch_pc is not incremented.
- Pop: when valid_id=1 and stall=0 and redirect=0, advance rd_ptr.
- Simultaneous push and pop: count unchanged. Push into a full queue cannot occur because of the issue rule; the bench asserts this.
- Redirect (overrides stall, push and pop):
  - count, rd_ptr and wr_ptr <= 0.
  - fetch_pc <= redirect_pc.
  - If a request is outstanding and not acked this cycle, set drop=1.
  - An ack in the redirect cycle is discarded.
  - The pending request still completes on the memory side; the new request to redirect_pc is issued only after it completes.
  - A second redirect while drop=1 only updates fetch_pc.
- Output: inst_id and pc_plus_four_id come from the FIFO head (registered storage, no imem_rdata bypass).

## Timing
- During reset and the first cycle after:
  - imem_req=0, valid_id=0, inst_id=0, pc_plus_four_id=0.
  - count=0, outstanding=0, drop=0, fetch_pc=RESET_PC.
- First imem_req: the cycle after reset deasserts.
- Latency: ack in cycle N → valid_id=1 in cycle N+1.
- Throughput: zero-wait memory (ack same cycle as req) → one instruction per cycle, with imem_addr advancing by 4 every cycle.
- Redirect in cycle N with no request outstanding:
  - valid_id=0 in N+1.
  - imem_req with imem_addr=redirect_pc in N+1.
  - First target instruction in N+2 (zero-wait memory).
- Redirect with a request pending: the new request rises the cycle after the dropped ack.
- stall=1 holds the head stable. Fetch continues until count + outstanding = DEPTH.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning addr-based words, stall=0 → imem_addr 0x100, 0x104, 0x108…; valid_id from cycle 2; pc_plus_four_id 0x104, 0x108… one per cycle.
- Hold stall=1 for 10 cycles → exactly DEPTH=4 entries fetched, then imem_req=0. inst_id stays at word@0x100. After release, the four entries drain in order with no gaps.
- Memory with 3-cycle latency → imem_addr stable across the wait cycles; valid_id pulses at most once per 3 cycles; no duplicate or skipped PCs.
- Redirect to 0x2000 while a 3-cycle request to 0x10C is pending → the 0x10C data is never presented; valid_id=0 until word@0x2000 appears with pc_plus_four_id=0x2004.
- Redirect in the same cycle as an ack and a pop → queue empty next cycle; ack data discarded; next imem_addr=redirect_pc.
- Fetch from 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 with pc_plus_four_id 0xFFFF_FFFC, 0x0, 0x4.
